// File: rtl/playlist_sequencer.sv
// Playlist sequencer: selects the current track, steps the ROM read address on each
// sample tick and inserts a silent gap between tracks (in-order/shuffle/choice/stop).
// Ports: clk/rst_n, sample_tick_i, pause_i, mode_i, choice_i, btn_next_i, btn_prev_i,
//        rand_val_i in; rom_addr_o, track_o, rom_en_o, sample_valid_o, playing_o, track_done_o out.
module playlist_sequencer #(
  parameter int NTRK      = 4,
  parameter int ADDR_W    = 11,
  parameter int LEN0      = 270,
  parameter int LEN1      = 220,
  parameter int LEN2      = 260,
  parameter int LEN3      = 10,
  parameter int GAP_TICKS = 48,
  parameter int PREV_TH   = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick_i,
  input  logic              pause_i,
  input  logic [1:0]        mode_i,
  input  logic [1:0]        choice_i,
  input  logic              btn_next_i,
  input  logic              btn_prev_i,
  input  logic [1:0]        rand_val_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [1:0]        track_o,
  output logic              rom_en_o,
  output logic              sample_valid_o,
  output logic              playing_o,
  output logic              track_done_o
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PLAY, S_PAUSED, S_GAP} state_e;

  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  function automatic bit len_ok();
    int lens [4];
    lens = '{LEN0, LEN1, LEN2, LEN3};
    if (NTRK < 2 || NTRK > 4) return 1'b0;
    for (int i = 0; i < NTRK; i++)
      if (lens[i] < 1 || lens[i] > (1 << ADDR_W) - 1) return 1'b0;
    return 1'b1;
  endfunction

  localparam bit LEN_OK = len_ok();

  function automatic logic [1:0] inc_trk(input logic [1:0] t);
    return (int'(t) >= NTRK - 1) ? 2'd0 : t + 2'd1;
  endfunction

  function automatic logic [1:0] dec_trk(input logic [1:0] t);
    return (t == 2'd0) ? 2'(NTRK - 1) : t - 2'd1;
  endfunction

  function automatic logic [1:0] mod_trk(input logic [1:0] v);
    return 2'(int'(v) % NTRK);
  endfunction

  function automatic logic [ADDR_W-1:0] last_addr(input logic [1:0] t);
    case (t)
      2'd0:    return ADDR_W'(LEN0 - 1);
      2'd1:    return ADDR_W'(LEN1 - 1);
      2'd2:    return ADDR_W'(LEN2 - 1);
      default: return ADDR_W'(LEN3 - 1);
    endcase
  endfunction

  state_e              state_q, state_d;
  state_e              ret_q, ret_d;      // state to resume after PAUSED
  logic [1:0]          track_q, track_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                adv_q, adv_d;
  logic                playing_q, sample_valid_q;
  logic                rom_en, track_done;
  logic [1:0]          rnd_trk;
  logic                prev_restarts;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    track_d    = track_q;
    addr_d     = addr_q;
    gap_d      = gap_q;
    adv_d      = adv_q;
    rom_en     = 1'b0;
    track_done = 1'b0;
    rnd_trk    = mod_trk(rand_val_i);
    // In a gap (or paused out of one) prev always steps back a track.
    prev_restarts = (mode_i == 2'd1 || int'(addr_q) >= PREV_TH) &&
                    state_q != S_GAP && !(state_q == S_PAUSED && ret_q == S_GAP);

    case (state_q)
      S_IDLE: begin
        if (mode_i != 2'd3 && !pause_i) begin
          state_d = S_SELECT;
          adv_d   = 1'b0;
        end
      end
      S_SELECT: begin
        if (mode_i == 2'd3) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else begin
          case (mode_i)
            2'd0:    track_d = adv_q ? inc_trk(track_q) : track_q;
            2'd1:    track_d = (rnd_trk == track_q) ? inc_trk(rnd_trk) : rnd_trk;
            default: track_d = mod_trk(choice_i);
          endcase
          addr_d  = '0;
          gap_d   = '0;
          state_d = S_PLAY;
        end
      end
      default: begin
        if (mode_i == 2'd3) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else if (pause_i && state_q != S_PAUSED) begin
          ret_d   = state_q;
          state_d = S_PAUSED;
        end else if (btn_next_i) begin
          state_d = S_SELECT;
          adv_d   = 1'b1;
        end else if (btn_prev_i) begin
          if (!prev_restarts) track_d = dec_trk(track_q);
          addr_d = '0;
          gap_d  = '0;
          if (state_q == S_GAP)    state_d = S_PLAY;
          if (state_q == S_PAUSED) ret_d   = S_PLAY;
        end else if (state_q == S_PAUSED) begin
          if (!pause_i) state_d = ret_q;
        end else if (mode_i == 2'd2 && mod_trk(choice_i) != track_q) begin
          state_d = S_SELECT;
          adv_d   = 1'b0;
        end else if (state_q == S_PLAY) begin
          if (sample_tick_i) begin
            rom_en = 1'b1;
            if (addr_q == last_addr(track_q)) begin
              track_done = 1'b1;
              state_d    = S_GAP;
              gap_d      = '0;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end else begin
          if (GAP_TICKS == 0) begin
            state_d = S_SELECT;
            adv_d   = 1'b1;
          end else if (sample_tick_i) begin
            if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
              state_d = S_SELECT;
              adv_d   = 1'b1;
            end else begin
              gap_d = gap_q + 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ret_q          <= S_PLAY;
      track_q        <= '0;
      addr_q         <= '0;
      gap_q          <= '0;
      adv_q          <= 1'b0;
      playing_q      <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ret_q          <= ret_d;
      track_q        <= track_d;
      addr_q         <= addr_d;
      gap_q          <= gap_d;
      adv_q          <= adv_d;
      playing_q      <= (state_d == S_PLAY);
      sample_valid_q <= rom_en;
    end
  end

  always @(posedge clk) begin
    assert (LEN_OK) else $error("playlist_sequencer: track length or NTRK out of range");
  end

  assign rom_addr_o     = addr_q;
  assign track_o        = track_q;
  assign rom_en_o       = rom_en;
  assign sample_valid_o = sample_valid_q;
  assign playing_o      = playing_q;
  assign track_done_o   = track_done;

endmodule

// File: tb/tb_playlist_sequencer.sv
module tb_playlist_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  mode = 2'd3;
  logic [1:0]  choice = 2'd0;
  logic        btn_next = 1'b0;
  logic        btn_prev = 1'b0;
  logic [1:0]  rand_val = 2'd0;
  logic [10:0] rom_addr;
  logic [1:0]  track;
  logic        rom_en, sample_valid, playing, track_done;

  playlist_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sample_tick_i(sample_tick), .pause_i(pause),
    .mode_i(mode), .choice_i(choice), .btn_next_i(btn_next), .btn_prev_i(btn_prev),
    .rand_val_i(rand_val), .rom_addr_o(rom_addr), .track_o(track), .rom_en_o(rom_en),
    .sample_valid_o(sample_valid), .playing_o(playing), .track_done_o(track_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  trk;
    logic [10:0] addr;
  } rd_t;

  rd_t        exp_q[$];
  logic [1:0] done_q[$];
  int         len_tb [4] = '{270, 220, 260, 10};
  int         checks = 0;
  int         errors = 0;
  int         t3_reads = 0;
  logic       prev_en = 1'b0;
  logic       prev_rst = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected reads / track ends whenever the DUT presents them.
  always @(negedge clk) begin
    rd_t        e;
    logic [1:0] d;
    if (rst_n && prev_rst) check("sample_valid", sample_valid, prev_en);
    if (rom_en) begin
      if (track == 2'd3) t3_reads++;
      if (exp_q.size() == 0) begin
        check("unexpected_read_addr", rom_addr, -1);
      end else begin
        e = exp_q.pop_front();
        check("read_track", track, e.trk);
        check("read_addr", rom_addr, e.addr);
      end
    end
    if (track_done) begin
      check("done_addr_last", rom_addr, len_tb[track] - 1);
      if (done_q.size() == 0) begin
        check("unexpected_track_done", track, -1);
      end else begin
        d = done_q.pop_front();
        check("done_track", track, d);
      end
    end
    prev_en  = rom_en;
    prev_rst = rst_n;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic play(input logic [1:0] trk, input int from, input int n);
    rd_t e;
    for (int i = 0; i < n; i++) begin
      e.trk  = trk;
      e.addr = 11'(from + i);
      exp_q.push_back(e);
    end
    if (from + n == len_tb[trk]) done_q.push_back(trk);
    ticks(n);
  endtask

  task automatic pulse_next();
    btn_next = 1'b1;
    cyc();
    btn_next = 1'b0;
    cyc();
  endtask

  task automatic pulse_prev();
    btn_prev = 1'b1;
    cyc();
    btn_prev = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_track"}, track, 0);
    check({tag, "_rom_en"}, rom_en, 0);
    check({tag, "_sample_valid"}, sample_valid, 0);
    check({tag, "_playing"}, playing, 0);
    check({tag, "_track_done"}, track_done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc(); cyc();
    check("stop_mode_playing", playing, 0);
    mode = 2'd0;
    cyc(); cyc();
    check("start_playing", playing, 1);
    check("start_track", track, 0);

    // T1: reset mid-play at address 57
    play(2'd0, 0, 57);
    check("t1_addr", rom_addr, 57);
    rst_n = 1'b0;
    #1;
    check_all_zero("t1_reset");
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    check("t1_restart_playing", playing, 1);
    check("t1_restart_addr", rom_addr, 0);

    // T2: full track 1, gap, advance to track 2
    pulse_next();
    check("t2_track1", track, 1);
    play(2'd1, 0, 220);
    check("t2_gap_playing", playing, 0);
    ticks(48);
    play(2'd2, 0, 5);
    check("t2_track2", track, 2);

    // T3: track 3 wraps to track 0
    pulse_next();
    check("t3_track3", track, 3);
    play(2'd3, 0, 10);
    ticks(48);
    play(2'd0, 0, 3);
    check("t3_wrap_track", track, 0);
    check("t3_reads", t3_reads, 10);

    // T4: pause at address 80 for 500 ticks
    play(2'd0, 3, 77);
    check("t4_addr", rom_addr, 80);
    pause = 1'b1;
    ticks(500);
    check("t4_paused_addr", rom_addr, 80);
    check("t4_paused_playing", playing, 0);
    pause = 1'b0;
    cyc();
    play(2'd0, 80, 1);

    // T5: prev restarts above threshold, steps back below it
    play(2'd0, 81, 69);
    check("t5_addr150", rom_addr, 150);
    pulse_prev();
    check("t5_restart_addr", rom_addr, 0);
    check("t5_restart_track", track, 0);
    play(2'd0, 0, 20);
    pulse_prev();
    check("t5_prev_track", track, 3);
    check("t5_prev_addr", rom_addr, 0);
    play(2'd3, 0, 2);

    // T6: shuffle collision, next+prev together, stop during gap
    pulse_prev();
    check("t6_prev_to2", track, 2);
    mode = 2'd1;
    rand_val = 2'd2;
    pulse_next();
    check("t6_shuffle_track", track, 3);
    play(2'd3, 0, 2);
    pulse_prev();
    check("t6_shuffle_prev_track", track, 3);
    check("t6_shuffle_prev_addr", rom_addr, 0);
    play(2'd3, 0, 1);
    mode = 2'd0;
    btn_next = 1'b1;
    btn_prev = 1'b1;
    cyc();
    btn_next = 1'b0;
    btn_prev = 1'b0;
    cyc();
    check("t6_next_wins_track", track, 0);
    play(2'd0, 0, 2);
    pulse_prev();
    play(2'd3, 0, 10);
    ticks(5);
    mode = 2'd3;
    cyc();
    check("t6_stop_playing", playing, 0);
    check("t6_stop_addr", rom_addr, 0);
    check("t6_stop_track", track, 3);
    ticks(3);

    // choice mode from idle, then choice change while playing
    mode = 2'd2;
    choice = 2'd1;
    cyc(); cyc();
    check("choice_track", track, 1);
    check("choice_playing", playing, 1);
    play(2'd1, 0, 3);
    choice = 2'd2;
    cyc(); cyc();
    check("choice_change_track", track, 2);
    check("choice_change_addr", rom_addr, 0);
    play(2'd2, 0, 2);

    repeat (4) cyc();
    check("reads_outstanding", exp_q.size(), 0);
    check("dones_outstanding", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
